oam_dma_ctrl: RTL and testbench

- OAM DMA engine behind register FF46; the initiator side of the OAM DMA path.
- A CPU write to FF46 starts a 160-byte copy from {src,00h}..{src,9Fh} into OAM FE00-FE9F.
- Drives dma_a, dma_run, vram_to_oam and oam_addr_ndma, which the OAM page consumes to select the DMA address and the data source.
- Generates the per-byte OAM write strobe.

---
 rtl/ppu_pkg.sv | 30 +++
 rtl/dma_byte_counter.sv | 36 +++
 rtl/oam_dma_ctrl.sv | 120 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: DMA state encoding, register addresses and
// the source-page helpers used by the OAM DMA engine.
package ppu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } dma_state_t;

   localparam logic [15:0] FF46_ADDR    = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;

   localparam logic [7:0]  VRAM_SRC_LO  = 8'h80;
   localparam logic [7:0]  VRAM_SRC_HI  = 8'h9F;

   localparam logic [7:0]  ECHO_SRC_LO  = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

   // Pages E0-FF fold back onto C0-DF (echo RAM).
   function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
      return (src >= ECHO_SRC_LO) ? (src - ECHO_OFFSET) : src;
   endfunction

   // True when a (folded) source page lies in VRAM.
   function automatic logic is_vram_src(input logic [7:0] page);
      return (page >= VRAM_SRC_LO) && (page <= VRAM_SRC_HI);
   endfunction

endpackage

// File: rtl/dma_byte_counter.sv
// Phase/byte counter for DMA engines: a phase counter that wraps once per
// byte and a byte index that advances on each wrap.
module dma_byte_counter #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int OAM_LEN         = 160
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       step,
   output logic [7:0] idx,
   output logic       wrap,
   output logic       last
);

   logic [2:0] cnt;

   // Phase counter rolls over to 0 and bumps the byte index on wrap.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= 3'd0;
         idx <= 8'd0;
      end else if (step) begin
         if (wrap) begin
            cnt <= 3'd0;
            idx <= idx + 8'd1;
         end else begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   assign wrap = (cnt == 3'(CYCLES_PER_BYTE - 1));
   assign last = (idx == 8'(OAM_LEN - 1));

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine behind FF46: copies OAM_LEN bytes from {src,00h} into OAM,
// holding the bus across restarts and strobing one OAM write per byte.
module oam_dma_ctrl
   import ppu_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int OAM_LEN         = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic [15:0] dma_a,
   output logic        dma_run,
   output logic        vram_to_oam,
   output logic        oam_addr_ndma,
   output logic        oam_wr,
   output logic        dma_done
);

   dma_state_t state;
   logic [7:0] src;
   logic       restart_flag;
   logic [7:0] idx;
   logic       byte_wrap;
   logic       byte_last;
   logic       ff46_hit;
   logic       ff46_wr;
   logic       cnt_clear;
   logic       cnt_step;
   logic [7:0] src_eff;

   assign ff46_hit = (a == FF46_ADDR);
   assign ff46_wr  = cpu_wr && ff46_hit;

   // Any FF46 write, the end of START and the end of the last byte all
   // restart the counter from zero; it only runs outside IDLE.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_step  = 1'b0;
      case (state)
         IDLE:    cnt_clear = 1'b1;
         START: begin
            cnt_step  = 1'b1;
            cnt_clear = ff46_wr || byte_wrap;
         end
         RUN: begin
            cnt_step  = 1'b1;
            cnt_clear = ff46_wr || (byte_wrap && byte_last);
         end
         default: cnt_clear = 1'b1;
      endcase
   end

   dma_byte_counter #(
      .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
      .OAM_LEN         (OAM_LEN)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .step  (cnt_step),
      .idx   (idx),
      .wrap  (byte_wrap),
      .last  (byte_last)
   );

   // Transfer sequencing; a write in RUN keeps the bus via restart_flag
   // until the restarted transfer reaches RUN again.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         src          <= 8'h00;
         restart_flag <= 1'b0;
         dma_done     <= 1'b0;
      end else begin
         dma_done <= 1'b0;
         if (ff46_wr) begin
            src <= d;
         end
         case (state)
            IDLE: begin
               if (ff46_wr) begin
                  state <= START;
               end
            end
            START: begin
               if (!ff46_wr && byte_wrap) begin
                  state        <= RUN;
                  restart_flag <= 1'b0;
               end
            end
            RUN: begin
               if (ff46_wr) begin
                  state        <= START;
                  restart_flag <= 1'b1;
               end else if (byte_wrap && byte_last) begin
                  state    <= IDLE;
                  dma_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign src_eff       = dma_src_eff(src);
   assign dma_run       = (state == RUN) || restart_flag;
   assign oam_addr_ndma = !dma_run;
   assign oam_wr        = (state == RUN) && byte_wrap;
   assign dma_a         = dma_run ? {src_eff, idx} : 16'h0000;
   assign vram_to_oam   = is_vram_src(src_eff);
   assign d_out         = src;
   assign d_oe          = cpu_rd && ff46_hit && !reset;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a scoreboard of expected OAM writes
// ({vram_to_oam, dma_a}) that is drained on every oam_wr strobe.
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [15:0] a;
   logic [7:0]  d;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [15:0] dma_a;
   logic        dma_run;
   logic        vram_to_oam;
   logic        oam_addr_ndma;
   logic        oam_wr;
   logic        dma_done;

   int total = 0;
   int bad   = 0;
   int wr_seen    = 0;
   int done_seen  = 0;
   int run_cycles = 0;

   logic [16:0] exp_q[$];
   logic [16:0] sb_exp;

   oam_dma_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_wr        (cpu_wr),
      .cpu_rd        (cpu_rd),
      .a             (a),
      .d             (d),
      .d_out         (d_out),
      .d_oe          (d_oe),
      .dma_a         (dma_a),
      .dma_run       (dma_run),
      .vram_to_oam   (vram_to_oam),
      .oam_addr_ndma (oam_addr_ndma),
      .oam_wr        (oam_wr),
      .dma_done      (dma_done)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Scoreboard drain plus bookkeeping of run time, strobes and done pulses.
   always @(negedge clk) begin
      if (dma_run) run_cycles++;
      if (dma_done) done_seen++;
      if (oam_wr) begin
         wr_seen++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $error("[TB] FAIL unexpected_oam_wr: observed dma_a=%h required=no write", dma_a);
         end else begin
            sb_exp = exp_q.pop_front();
            assert ({vram_to_oam, dma_a} === sb_exp) else begin
               bad++;
               $error("[TB] FAIL oam_wr_addr: observed vram=%b dma_a=%h required vram=%b dma_a=%h",
                      vram_to_oam, dma_a, sb_exp[16], sb_exp[15:0]);
            end
         end
      end
   end

   function automatic logic [7:0] model_eff(input logic [7:0] s);
      if (s >= 8'hE0) return s - 8'h20;
      return s;
   endfunction

   // Queue the 160 writes a transfer from page s is expected to make.
   task automatic push_transfer(input logic [7:0] s);
      logic [7:0] eff;
      logic       vram;
      eff  = model_eff(s);
      vram = (eff >= 8'h80) && (eff <= 8'h9F);
      for (int i = 0; i < 160; i++) exp_q.push_back({vram, eff, 8'(i)});
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic wr, input logic rd, input logic [15:0] addr, input logic [7:0] data);
      @(posedge clk);
      #1;
      cpu_wr = wr;
      cpu_rd = rd;
      a      = addr;
      d      = data;
   endtask

   // Single-cycle FF46 write; returns 1 ns after the edge that samples it.
   task automatic ff46_write(input logic [7:0] data);
      apply_stimulus(1'b1, 1'b0, 16'hFF46, data);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic clear_counts();
      wr_seen    = 0;
      done_seen  = 0;
      run_cycles = 0;
   endtask

   task automatic wait_wr(input int n, input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (wr_seen >= n) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         total++;
         bad++;
         $error("[TB] FAIL %s_timeout: observed wr=%0d required=%0d", tag, wr_seen, n);
      end
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dma_done === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         total++;
         bad++;
         $error("[TB] FAIL %s_timeout: observed no dma_done required=dma_done", tag);
      end
   endtask

   initial begin
      reset  = 1'b1;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      a      = 16'h0000;
      d      = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_dma_run", dma_run, 0);
      check_output("rst_ndma", oam_addr_ndma, 1);
      check_output("rst_oam_wr", oam_wr, 0);
      check_output("rst_done", dma_done, 0);
      check_output("rst_dma_a", dma_a, 0);
      check_output("rst_vram", vram_to_oam, 0);
      check_output("rst_d_oe", d_oe, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic transfer from C1h: START latency, 160 writes, 640 run clocks
      $display("[TB] transfer C1h");
      ff46_write(8'hC1);
      clear_counts();
      push_transfer(8'hC1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_output("start_run_low", dma_run, 0);
         check_output("start_no_wr", oam_wr, 0);
      end
      @(negedge clk);
      check_output("run_rise", dma_run, 1);
      check_output("run_ndma", oam_addr_ndma, 0);
      check_output("run_first_a", dma_a, 32'hC100);
      wait_done(800, "c1_done");
      check_output("c1_end_run", dma_run, 0);
      repeat (3) @(negedge clk);
      #1;
      check_output("c1_wr_count", wr_seen, 160);
      check_output("c1_run_cycles", run_cycles, 640);
      check_output("c1_done_count", done_seen, 1);
      check_output("c1_queue_empty", exp_q.size(), 0);

      // VRAM source and echo-page fold
      $display("[TB] transfer 85h and FEh");
      ff46_write(8'h85);
      clear_counts();
      push_transfer(8'h85);
      wait_done(800, "v85_done");
      ff46_write(8'hFE);
      clear_counts();
      push_transfer(8'hFE);
      wait_done(800, "fe_done");
      repeat (2) @(negedge clk);
      #1;
      check_output("fe_wr_count", wr_seen, 160);
      check_output("fe_queue_empty", exp_q.size(), 0);

      // Restart in RUN at idx 50
      $display("[TB] restart at idx 50");
      ff46_write(8'hC0);
      clear_counts();
      push_transfer(8'hC0);
      wait_wr(50, 400, "c0_idx50");
      exp_q.delete();
      push_transfer(8'hD0);
      ff46_write(8'hD0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_output("restart_run_held", dma_run, 1);
         check_output("restart_no_wr", oam_wr, 0);
         check_output("restart_a", dma_a, 32'hD000);
      end
      wait_done(900, "d0_done");
      repeat (3) @(negedge clk);
      #1;
      check_output("restart_wr_count", wr_seen, 210);
      check_output("restart_run_cycles", run_cycles, 845);
      check_output("restart_done_count", done_seen, 1);

      // Reset mid-transfer at idx 80
      $display("[TB] reset at idx 80");
      ff46_write(8'hC1);
      clear_counts();
      push_transfer(8'hC1);
      wait_wr(80, 600, "c1_idx80");
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("mid_rst_run", dma_run, 0);
      check_output("mid_rst_ndma", oam_addr_ndma, 1);
      check_output("mid_rst_wr", oam_wr, 0);
      check_output("mid_rst_a", dma_a, 0);
      check_output("mid_rst_done", dma_done, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b1, 16'hFF46, 8'h00);
      @(negedge clk);
      check_output("mid_rst_d_out", d_out, 8'h00);
      check_output("mid_rst_d_oe", d_oe, 1);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      repeat (700) @(negedge clk);
      #1;
      check_output("mid_rst_no_done", done_seen, 0);
      check_output("mid_rst_wr_count", wr_seen, 80);

      // Readback
      $display("[TB] readback A5h");
      ff46_write(8'hA5);
      clear_counts();
      push_transfer(8'hA5);
      apply_stimulus(1'b0, 1'b1, 16'hFF46, 8'h00);
      @(negedge clk);
      check_output("rd_d_out", d_out, 8'hA5);
      check_output("rd_d_oe", d_oe, 1);
      apply_stimulus(1'b0, 1'b1, 16'hFF45, 8'h00);
      @(negedge clk);
      check_output("rd_ff45_d_oe", d_oe, 0);
      apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      wait_done(800, "a5_done");
      repeat (2) @(negedge clk);
      #1;
      check_output("a5_wr_count", wr_seen, 160);

      // Write coincident with the final strobe
      $display("[TB] restart on final byte");
      ff46_write(8'hC1);
      clear_counts();
      push_transfer(8'hC1);
      wait_wr(159, 800, "c1_idx159");
      repeat (4) @(posedge clk);
      #1;
      cpu_wr = 1'b1;
      a      = 16'hFF46;
      d      = 8'hC2;
      @(negedge clk);
      check_output("final_wr_strobe", oam_wr, 1);
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
      a      = 16'h0000;
      push_transfer(8'hC2);
      @(negedge clk);
      check_output("final_no_done", dma_done, 0);
      check_output("final_run_held", dma_run, 1);
      wait_done(900, "c2_done");
      repeat (3) @(negedge clk);
      #1;
      check_output("final_wr_count", wr_seen, 320);
      check_output("final_done_count", done_seen, 1);
      check_output("final_run_cycles", run_cycles, 1284);
      check_output("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
